vx_uuid_commit_monitor: RTL and testbench

Per-core checker that consumes the per-warp instruction UUIDs stamped at schedule time and tracks them through to commit. It sits beside the issue/commit path downstream of the UUID generator. It keeps per-warp in-flight counts and the last issued and last committed sequence numbers. It reports malformed, out-of-sequence, overflowing or out-of-order UUIDs as registered error events with a sticky summary flag. It is a debug/verification aid with no backpressure on the datapath.

---
 rtl/vx_uuid_commit_monitor.sv | 125 ++++++++++++
 tb/tb_vx_uuid_commit_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vx_uuid_commit_monitor.sv
// vx_uuid_commit_monitor: tracks per-warp instruction UUIDs from issue to commit and flags sequence violations
module vx_uuid_commit_monitor #(
  parameter int CORE_ID = 0,
  parameter int MAX_INFLIGHT = 16,
  localparam int NUM_WARPS = 4,
  localparam int NW_BITS = 2,
  localparam int NW_WIDTH = 2,
  localparam int UUID_WIDTH = 44,
  localparam int GNW_WIDTH = UUID_WIDTH - 32,
  localparam int CW = $clog2(MAX_INFLIGHT + 1),
  localparam int TW = CW + NW_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [NW_WIDTH-1:0]   issue_wid,
  input  logic [UUID_WIDTH-1:0] issue_uuid,
  input  logic                  commit_valid,
  input  logic [NW_WIDTH-1:0]   commit_wid,
  input  logic [UUID_WIDTH-1:0] commit_uuid,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [NW_WIDTH-1:0]   err_wid,
  output logic [UUID_WIDTH-1:0] err_uuid,
  output logic                  err_sticky,
  output logic [TW-1:0]         total_inflight,
  output logic                  all_idle
);
  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] BAD_GID = 3'd1;
  localparam logic [2:0] ISSUE_SEQ = 3'd2;
  localparam logic [2:0] INFLIGHT_OVF = 3'd3;
  localparam logic [2:0] COMMIT_UNDF = 3'd4;
  localparam logic [2:0] COMMIT_ORDER = 3'd5;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [GNW_WIDTH-1:0] GBASE = GNW_WIDTH'(CORE_ID) << NW_BITS;

  logic [NUM_WARPS-1:0] has_issued, has_nxt;
  logic [31:0]          last_iss [NUM_WARPS];
  logic [31:0]          last_iss_nxt [NUM_WARPS];
  logic [31:0]          last_cmt [NUM_WARPS];
  logic [31:0]          last_cmt_nxt [NUM_WARPS];
  logic [CW-1:0]        inflight [NUM_WARPS];
  logic [CW-1:0]        inflight_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] inc, dec;
  logic [TW-1:0]        sum_nxt;
  logic                 idle_nxt;

  logic [GNW_WIDTH-1:0] iss_gid, cmt_gid, iss_g, cmt_g;
  logic [31:0]          iss_seq, cmt_seq, iss_exp;
  logic                 same, cmt_undf, iss_err, cmt_err;
  logic [2:0]           iss_code, cmt_code;

  assign iss_gid = issue_uuid[UUID_WIDTH-1:32];
  assign cmt_gid = commit_uuid[UUID_WIDTH-1:32];
  assign iss_seq = issue_uuid[31:0];
  assign cmt_seq = commit_uuid[31:0];
  assign iss_g = GBASE + GNW_WIDTH'(issue_wid);
  assign cmt_g = GBASE + GNW_WIDTH'(commit_wid);
  assign same = issue_valid && commit_valid && issue_wid == commit_wid;
  assign iss_exp = has_issued[issue_wid] ? last_iss[issue_wid] + 32'd1 : 32'd1;
  // A same-warp issue keeps the count non-zero, so the commit cannot underflow.
  assign cmt_undf = inflight[commit_wid] == '0 && !same;

  assign iss_code = (iss_gid != iss_g) ? BAD_GID :
                    (iss_seq != iss_exp) ? ISSUE_SEQ :
                    (inflight[issue_wid] == MAX_CNT && !same) ? INFLIGHT_OVF : NONE;
  assign cmt_code = (cmt_gid != cmt_g) ? BAD_GID :
                    cmt_undf ? COMMIT_UNDF :
                    (cmt_seq != last_cmt[commit_wid] + 32'd1) ? COMMIT_ORDER : NONE;
  assign iss_err = issue_valid && iss_code != NONE;
  assign cmt_err = commit_valid && cmt_code != NONE;

  assign inc = issue_valid ? (NUM_WARPS'(1) << issue_wid) : '0;
  assign dec = (commit_valid && !cmt_undf) ? (NUM_WARPS'(1) << commit_wid) : '0;

  always_comb begin
    has_nxt = has_issued;
    last_iss_nxt = last_iss;
    last_cmt_nxt = last_cmt;
    sum_nxt = '0;
    idle_nxt = 1'b1;
    if (issue_valid) begin
      has_nxt[issue_wid] = 1'b1;
      last_iss_nxt[issue_wid] = iss_seq;
    end
    if (commit_valid && !cmt_undf)
      last_cmt_nxt[commit_wid] = cmt_seq;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inflight_nxt[w] = (inc[w] && !dec[w]) ? ((inflight[w] == MAX_CNT) ? MAX_CNT : inflight[w] + CW'(1)) :
                        (dec[w] && !inc[w]) ? inflight[w] - CW'(1) : inflight[w];
      sum_nxt = sum_nxt + TW'(inflight_nxt[w]);
      idle_nxt = idle_nxt && inflight_nxt[w] == '0;
    end
  end

  // Commit errors win over issue errors in the same cycle; both still set the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_issued <= '0;
      last_iss <= '{default: '0};
      last_cmt <= '{default: '0};
      inflight <= '{default: '0};
      err_valid <= 1'b0;
      err_code <= NONE;
      err_wid <= '0;
      err_uuid <= '0;
      err_sticky <= 1'b0;
      total_inflight <= '0;
      all_idle <= 1'b1;
    end else begin
      has_issued <= has_nxt;
      last_iss <= last_iss_nxt;
      last_cmt <= last_cmt_nxt;
      inflight <= inflight_nxt;
      err_valid <= iss_err || cmt_err;
      err_code <= cmt_err ? cmt_code : iss_err ? iss_code : NONE;
      err_wid <= cmt_err ? commit_wid : iss_err ? issue_wid : '0;
      err_uuid <= cmt_err ? commit_uuid : iss_err ? issue_uuid : '0;
      err_sticky <= err_sticky || iss_err || cmt_err;
      total_inflight <= sum_nxt;
      all_idle <= idle_nxt;
    end
  end
endmodule

// File: tb/tb_vx_uuid_commit_monitor.sv
// tb_vx_uuid_commit_monitor: directed scoreboard bench for the UUID commit monitor (CORE_ID=2, 4 warps)
module tb_vx_uuid_commit_monitor;
  localparam int UW = 44;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          issue_valid = 1'b0;
  logic [1:0]    issue_wid = '0;
  logic [UW-1:0] issue_uuid = '0;
  logic          commit_valid = 1'b0;
  logic [1:0]    commit_wid = '0;
  logic [UW-1:0] commit_uuid = '0;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [1:0]    err_wid;
  logic [UW-1:0] err_uuid;
  logic          err_sticky;
  logic [6:0]    total_inflight;
  logic          all_idle;

  vx_uuid_commit_monitor #(.CORE_ID(2), .MAX_INFLIGHT(16)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wid(issue_wid), .issue_uuid(issue_uuid),
    .commit_valid(commit_valid), .commit_wid(commit_wid), .commit_uuid(commit_uuid),
    .err_valid(err_valid), .err_code(err_code), .err_wid(err_wid), .err_uuid(err_uuid),
    .err_sticky(err_sticky), .total_inflight(total_inflight), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    bit            ev;
    logic [2:0]    code;
    logic [1:0]    wid;
    logic [UW-1:0] uuid;
    bit            sticky;
    int            tot;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   sticky_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [UW-1:0] uid(input logic [1:0] w, input logic [31:0] s);
    logic [11:0] g;
    g = 12'd8 + 12'(w);
    return {g, s};
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("err_valid", 64'(err_valid), 64'(e.ev));
      if (e.ev) begin
        chk("err_code", 64'(err_code), 64'(e.code));
        chk("err_wid", 64'(err_wid), 64'(e.wid));
        chk("err_uuid", 64'(err_uuid), 64'(e.uuid));
      end
      chk("err_sticky", 64'(err_sticky), 64'(e.sticky));
      if (e.tot >= 0) begin
        chk("total_inflight", 64'(total_inflight), 64'(e.tot));
        chk("all_idle", 64'(all_idle), 64'(e.tot == 0));
      end
    end else if (!reset && err_valid) begin
      chk("unexpected_err", 64'(err_valid), 64'(0));
    end
  end

  task automatic step(input bit iv, input logic [1:0] iw, input logic [UW-1:0] iu,
                      input bit cv, input logic [1:0] cw, input logic [UW-1:0] cu,
                      input logic [2:0] ec, input logic [1:0] ew, input logic [UW-1:0] eu, input int et);
    exp_t e;
    @(negedge clk);
    issue_valid = iv; issue_wid = iw; issue_uuid = iu;
    commit_valid = cv; commit_wid = cw; commit_uuid = cu;
    if (ec != 3'd0) sticky_exp = 1;
    e.due = cyc + 1; e.ev = ec != 3'd0; e.code = ec; e.wid = ew; e.uuid = eu;
    e.sticky = sticky_exp; e.tot = et;
    q.push_back(e);
  endtask

  task automatic iss(input logic [1:0] w, input logic [UW-1:0] u, input logic [2:0] ec, input int et);
    step(1, w, u, 0, 2'd0, '0, ec, w, u, et);
  endtask

  task automatic cmt(input logic [1:0] w, input logic [UW-1:0] u, input logic [2:0] ec, input int et);
    step(0, 2'd0, '0, 1, w, u, ec, w, u, et);
  endtask

  task automatic idle(input int et);
    step(0, 2'd0, '0, 0, 2'd0, '0, 3'd0, 2'd0, '0, et);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_err_valid", 64'(err_valid), 64'(0));
    chk("rst_err_code", 64'(err_code), 64'(0));
    chk("rst_sticky", 64'(err_sticky), 64'(0));
    chk("rst_total", 64'(total_inflight), 64'(0));
    chk("rst_all_idle", 64'(all_idle), 64'(1));
    reset = 1'b0;
    // clean issue/commit stream on warp 1
    iss(2'd1, uid(2'd1, 32'd1), 3'd0, 1);
    iss(2'd1, uid(2'd1, 32'd2), 3'd0, 2);
    iss(2'd1, uid(2'd1, 32'd3), 3'd0, 3);
    cmt(2'd1, uid(2'd1, 32'd1), 3'd0, 2);
    cmt(2'd1, uid(2'd1, 32'd2), 3'd0, 1);
    cmt(2'd1, uid(2'd1, 32'd3), 3'd0, 0);
    // wrong global warp id; state still updates
    iss(2'd0, 44'h1, 3'd1, 1);
    // sequence gap then recovery
    iss(2'd3, uid(2'd3, 32'd1), 3'd0, 2);
    iss(2'd3, uid(2'd3, 32'd3), 3'd2, 3);
    iss(2'd3, uid(2'd3, 32'd4), 3'd0, 4);
    // fill warp 2 to the limit, then overflow
    for (int s = 1; s <= 16; s++) iss(2'd2, uid(2'd2, 32'(s)), 3'd0, 4 + s);
    iss(2'd2, uid(2'd2, 32'd17), 3'd3, 20);
    step(1, 2'd2, uid(2'd2, 32'd18), 1, 2'd2, uid(2'd2, 32'd1), 3'd0, 2'd0, '0, 20);
    // underflow on idle warp, then commit order with resync
    cmt(2'd1, uid(2'd1, 32'd4), 3'd4, 20);
    iss(2'd1, uid(2'd1, 32'd4), 3'd0, 21);
    iss(2'd1, uid(2'd1, 32'd5), 3'd0, 22);
    cmt(2'd1, uid(2'd1, 32'd5), 3'd5, 21);
    cmt(2'd1, uid(2'd1, 32'd6), 3'd0, 20);
    // wrap 0xFFFF_FFFF -> 0
    iss(2'd0, uid(2'd0, 32'hFFFF_FFFF), 3'd2, 21);
    iss(2'd0, uid(2'd0, 32'd0), 3'd0, 22);
    // issue error and commit error together: commit wins
    step(1, 2'd0, uid(2'd0, 32'd5), 1, 2'd1, uid(2'd1, 32'd7), 3'd4, 2'd1, uid(2'd1, 32'd7), 23);
    cmt(2'd3, {12'd5, 32'd1}, 3'd1, 22);
    idle(22);
    iss(2'd1, uid(2'd1, 32'd1), 3'd2, 23);
    @(negedge clk);
    issue_valid = 1'b0; commit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_err_valid", 64'(err_valid), 64'(0));
    chk("async_err_code", 64'(err_code), 64'(0));
    chk("async_sticky", 64'(err_sticky), 64'(0));
    chk("async_total", 64'(total_inflight), 64'(0));
    chk("async_all_idle", 64'(all_idle), 64'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sticky_exp = 0;
    // tracking restarts at seq 1
    iss(2'd1, uid(2'd1, 32'd1), 3'd0, 1);
    cmt(2'd1, uid(2'd1, 32'd1), 3'd0, 0);
    idle(0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
